// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port and decode issue port of the fetch sequencer.
// master = sequencer side, slave = memory/decode side.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_offset;

  modport master (
    output imem_req, imem_addr, instr_valid, instr,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Single-outstanding instruction fetch controller: owns the PC, fetches over
// req/ack, issues over valid/ready, applies branch decisions, halts and faults.
module fetch_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt_req,
  fetch_sequencer_if.master bus,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  instr_count
);
  localparam int TCNT_W = 8;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALTED, S_FAULT} state_t;

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] instr_q;
  logic [TCNT_W-1:0]  tcnt;
  logic               halt_pending;
  logic               hs;
  logic               can_start;

  assign hs        = (state == S_ISSUE) && bus.instr_ready;
  assign can_start = (state == S_IDLE) || (state == S_HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALTED: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ack)                     state_nxt = S_ISSUE;
        else if (tcnt == TCNT_W'(TIMEOUT))    state_nxt = S_FAULT;
      end
      S_ISSUE: if (hs) state_nxt = (halt_pending || halt_req) ? S_HALTED : S_FETCH;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req    = (state == S_FETCH);
    bus.imem_addr   = pc_out;
    bus.instr_valid = (state == S_ISSUE);
    bus.instr       = instr_q;
    busy            = (state == S_FETCH) || (state == S_ISSUE);
    halted          = (state == S_HALTED);
    fault           = (state == S_FAULT);
  end

  // tcnt holds the index of the current FETCH cycle; zero whenever not fetching
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out       <= '0;
      instr_q      <= '0;
      instr_count  <= '0;
      tcnt         <= '0;
      halt_pending <= 1'b0;
    end else begin
      if (state == S_FETCH && !bus.imem_ack) tcnt <= tcnt + 1'b1;
      else                                   tcnt <= '0;

      if (state == S_FETCH && bus.imem_ack) instr_q <= bus.imem_rdata;

      if (hs) begin
        pc_out      <= pc_out + (bus.branch_taken ? bus.branch_offset : ADDR_W'(1));
        instr_count <= instr_count + 1'b1;
      end

      if (state_nxt == S_HALTED && state != S_HALTED)
        halt_pending <= 1'b0;
      else if (halt_req && (busy || (can_start && start)))
        halt_pending <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory model pushes expected words on ack,
// decode monitor pops and compares on each handshake.
module tb_fetch_sequencer;
  localparam int ADDR_W = 5, INSTR_W = 16, TIMEOUT = 15, CNT_W = 16;

  logic clk = 1'b0;
  logic reset, start, halt_req;
  logic [ADDR_W-1:0]  pc_out;
  logic               busy, halted, fault;
  logic [CNT_W-1:0]   instr_count;
  logic               mem_ack = 1'b0, late_ack = 1'b0, rdy = 1'b0, bt = 1'b0;
  logic [ADDR_W-1:0]  off = '0;
  logic [INSTR_W-1:0] mem_data = '0;
  int                 mem_delay = 2, mem_cnt = 0;
  logic [INSTR_W-1:0] sb[$];
  logic [ADDR_W-1:0]  exp_pc = '0;
  logic [CNT_W-1:0]   exp_cnt = '0;
  int                 n_tests = 0, n_fail = 0;

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();
  assign bus.imem_ack      = mem_ack | late_ack;
  assign bus.imem_rdata    = mem_data;
  assign bus.instr_ready   = rdy;
  assign bus.branch_taken  = bt;
  assign bus.branch_offset = off;

  fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .bus(bus),
    .pc_out(pc_out), .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory: ack in FETCH cycle index mem_delay with 16'hA000 | addr
  always @(negedge clk) begin
    if (bus.imem_req && !mem_ack) begin
      if (mem_cnt == mem_delay) begin
        mem_ack  = 1'b1;
        mem_data = 16'hA000 | 16'(bus.imem_addr);
        sb.push_back(mem_data);
        chk("addr", 32'(bus.imem_addr), 32'(exp_pc));
        mem_cnt  = 0;
      end else mem_cnt++;
    end else begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end
  end

  // decode: handshake completes at the coming posedge
  always @(negedge clk) begin
    if (!reset && bus.instr_valid && rdy) begin
      if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else chk("instr", 32'(bus.instr), 32'(sb.pop_front()));
      exp_pc  = exp_pc + (bt ? off : ADDR_W'(1));
      exp_cnt = exp_cnt + 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!bus.instr_valid && n < 60) begin tick; n++; end
    chk("valid_wait", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic issue_one(input logic b, input logic [ADDR_W-1:0] o);
    wait_valid;
    bt = b; off = o;
    tick;
    bt = 1'b0; off = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1; tick; tick;
    sb.delete(); exp_pc = '0; exp_cnt = '0;
    reset = 1'b0; tick;
  endtask

  initial begin
    logic [INSTR_W-1:0] h_instr;
    logic [ADDR_W-1:0]  h_pc;
    logic [CNT_W-1:0]   c0;
    int                 n;
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; rdy = 1'b1;
    #12;
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_cnt", 32'(instr_count), 32'd0);
    tick; reset = 1'b0; tick; tick;
    chk("idle_no_req", 32'(bus.imem_req), 32'd0);

    // sequential fetch 0..3
    pulse_start;
    repeat (4) issue_one(1'b0, '0);
    chk("seq_pc", 32'(pc_out), 32'd4);
    chk("seq_cnt", 32'(instr_count), 32'd4);

    // branches and wrap
    issue_one(1'b1, 5'b11101);
    chk("br_pc", 32'(pc_out), 32'd1);
    chk("br_addr", 32'(bus.imem_addr), 32'd1);
    chk("br_req", 32'(bus.imem_req), 32'd1);
    issue_one(1'b1, 5'b11101);
    chk("br_pc30", 32'(pc_out), 32'd30);
    issue_one(1'b0, '0);
    chk("pc31", 32'(pc_out), 32'd31);
    issue_one(1'b0, '0);
    chk("pc_wrap", 32'(pc_out), 32'd0);

    // decode stall
    rdy = 1'b0;
    wait_valid;
    h_instr = bus.instr; h_pc = pc_out; c0 = instr_count;
    chk("stall_sb", 32'(h_instr), 32'(sb[0]));
    repeat (5) begin
      tick;
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", 32'(bus.instr), 32'(h_instr));
      chk("stall_pc", 32'(pc_out), 32'(h_pc));
      chk("stall_req", 32'(bus.imem_req), 32'd0);
    end
    rdy = 1'b1; tick; rdy = 1'b0;
    chk("stall_one", 32'(instr_count), 32'(c0 + 1'b1));
    repeat (4) tick;
    chk("stall_next_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_one_only", 32'(instr_count), 32'(c0 + 1'b1));

    // halt mid-fetch
    rdy = 1'b1; tick;
    chk("halt_in_fetch", 32'(bus.imem_req), 32'd1);
    halt_req = 1'b1; tick; halt_req = 1'b0;
    n = 0;
    while (!halted && n < 60) begin tick; n++; end
    chk("halted", 32'(halted), 32'd1);
    chk("halt_cnt", 32'(instr_count), 32'(exp_cnt));
    chk("halt_pc", 32'(pc_out), 32'(exp_pc));
    repeat (3) begin
      tick;
      chk("halt_req_low", 32'(bus.imem_req), 32'd0);
      chk("halt_busy", 32'(busy), 32'd0);
    end
    h_pc = pc_out;
    pulse_start;
    chk("resume_req", 32'(bus.imem_req), 32'd1);
    chk("resume_addr", 32'(bus.imem_addr), 32'(h_pc));
    issue_one(1'b0, '0);
    chk("resume_cnt", 32'(instr_count), 32'(exp_cnt));

    // fetch timeout
    do_reset;
    mem_delay = 16;
    pulse_start;
    n = 0;
    while (bus.imem_req && n < 300) begin n++; tick; end
    chk("to_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    late_ack = 1'b1; tick; late_ack = 1'b0;
    chk("to_late_ack", 32'(fault), 32'd1);
    chk("to_no_valid", 32'(bus.instr_valid), 32'd0);
    pulse_start;
    chk("to_start_ign", 32'(fault), 32'd1);
    chk("to_start_req", 32'(bus.imem_req), 32'd0);
    do_reset;
    chk("to_cleared", 32'(fault), 32'd0);
    chk("to_rst_pc", 32'(pc_out), 32'd0);

    // ack in the last legal cycle
    mem_delay = TIMEOUT;
    pulse_start;
    issue_one(1'b0, '0);
    chk("edge_fault", 32'(fault), 32'd0);
    chk("edge_cnt", 32'(instr_count), 32'd1);

    // async reset during ISSUE
    mem_delay = 2; rdy = 1'b0;
    wait_valid;
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.instr_valid), 32'd0);
    chk("ar_instr", 32'(bus.instr), 32'd0);
    chk("ar_pc", 32'(pc_out), 32'd0);
    chk("ar_cnt", 32'(instr_count), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    tick; sb.delete(); exp_pc = '0; exp_cnt = '0;
    reset = 1'b0; rdy = 1'b1;
    repeat (5) begin
      tick;
      chk("ar_idle_req", 32'(bus.imem_req), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
